// File: rtl/audio_slot_controller_if.sv
// Raw board buttons plus the recorder's status bits, slot selections and sample-memory strobes.
// master = controller (drives status and memory side); slave = board/memory side.
interface audio_slot_controller_if #(
    parameter int ADDR_W = 16
) ();
    logic              btn_rec_sel;
    logic              btn_play_sel;
    logic              btn_record;
    logic              btn_play;
    logic              play_number;
    logic              rec_number;
    logic              recording;
    logic              playing;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W:0]   mem_addr;

    modport master (
        input  btn_rec_sel, btn_play_sel, btn_record, btn_play,
        output play_number, rec_number, recording, playing, mem_we, mem_re, mem_addr
    );

    modport slave (
        output btn_rec_sel, btn_play_sel, btn_record, btn_play,
        input  play_number, rec_number, recording, playing, mem_we, mem_re, mem_addr
    );
endinterface

// File: rtl/audio_slot_controller.sv
// Two-slot recorder control: debounced buttons -> IDLE/RECORD/PLAY with per-sample memory strobes.
// Press pulse 2+DEBOUNCE_CYCLES+1 cycles after a clean edge; state one cycle later; no backpressure.
module audio_slot_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SAMPLE_DIV      = 12500,
    parameter int ADDR_W          = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    audio_slot_controller_if.master bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(SAMPLE_DIV + 1);
    localparam int LEN_W = ADDR_W + 1;
    localparam int B_REC_SEL  = 0;
    localparam int B_PLAY_SEL = 1;
    localparam int B_RECORD   = 2;
    localparam int B_PLAY     = 3;
    localparam logic [LEN_W-1:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY} state_t;

    logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]        acc_q, acc_d, acc_prev_q, acc_prev_d;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];
    logic [3:0]        press;

    state_t            state_q, state_d;
    logic              slot_q, slot_d;
    logic              rec_num_q, rec_num_d;
    logic              play_num_q, play_num_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [LEN_W-1:0]  len_q [2];
    logic [LEN_W-1:0]  len_d [2];
    logic [LEN_W-1:0]  addr_q, addr_d;
    logic              tick, we_now, re_now;

    // Counter runs only while the synchronized level disagrees with the accepted one.
    always_comb begin
        sync1_d    = {bus.btn_play, bus.btn_record, bus.btn_play_sel, bus.btn_rec_sel};
        sync2_d    = sync1_q;
        acc_prev_d = acc_q;
        acc_d      = acc_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != acc_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                    acc_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press = acc_q & ~acc_prev_q;
    assign tick  = (div_q == DIV_W'(SAMPLE_DIV));

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        rec_num_d  = rec_num_q;
        play_num_d = play_num_q;
        idx_d      = idx_q;
        div_d      = div_q;
        len_d      = len_q;
        addr_d     = addr_q;
        we_now     = 1'b0;
        re_now     = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (press[B_REC_SEL])  rec_num_d  = ~rec_num_q;
                if (press[B_PLAY_SEL]) play_num_d = ~play_num_q;
                if (press[B_RECORD]) begin
                    state_d = S_RECORD;
                    slot_d  = rec_num_q;
                    idx_d   = '0;
                end else if (press[B_PLAY] && (len_q[play_num_q] != '0)) begin
                    state_d = S_PLAY;
                    slot_d  = play_num_q;
                    idx_d   = '0;
                end
            end
            S_RECORD: begin
                div_d = tick ? DIV_W'(1) : div_q + DIV_W'(1);
                if (press[B_RECORD]) begin
                    state_d       = S_IDLE;
                    len_d[slot_q] = {1'b0, idx_q};
                end else if (tick) begin
                    we_now = 1'b1;
                    addr_d = {slot_q, idx_q};
                    idx_d  = idx_q + ADDR_W'(1);
                    if (&idx_q) begin
                        state_d       = S_IDLE;
                        len_d[slot_q] = FULL_LEN;
                    end
                end
            end
            S_PLAY: begin
                div_d = tick ? DIV_W'(1) : div_q + DIV_W'(1);
                if (press[B_PLAY]) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    re_now = 1'b1;
                    addr_d = {slot_q, idx_q};
                    idx_d  = idx_q + ADDR_W'(1);
                    if ({1'b0, idx_q} == len_q[slot_q] - LEN_W'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            acc_q      <= '0;
            acc_prev_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            state_q    <= S_IDLE;
            slot_q     <= 1'b0;
            rec_num_q  <= 1'b0;
            play_num_q <= 1'b0;
            idx_q      <= '0;
            div_q      <= '0;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            addr_q     <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            acc_q      <= acc_d;
            acc_prev_q <= acc_prev_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            slot_q     <= slot_d;
            rec_num_q  <= rec_num_d;
            play_num_q <= play_num_d;
            idx_q      <= idx_d;
            div_q      <= div_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
        end
    end

    // Address is live during a strobe and otherwise holds the last strobed location.
    assign bus.mem_addr    = (we_now || re_now) ? {slot_q, idx_q} : addr_q;
    assign bus.mem_we      = we_now;
    assign bus.mem_re      = re_now;
    assign bus.recording   = (state_q == S_RECORD);
    assign bus.playing     = (state_q == S_PLAY);
    assign bus.rec_number  = rec_num_q;
    assign bus.play_number = play_num_q;
endmodule

// File: tb/tb_audio_slot_controller.sv
// Directed scenarios plus randomized button traffic, checked every cycle against a behavioural model.
module tb_audio_slot_controller;
    localparam int D = 4;
    localparam int S = 3;
    localparam int A = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    audio_slot_controller_if #(.ADDR_W(A)) bus ();

    audio_slot_controller #(.DEBOUNCE_CYCLES(D), .SAMPLE_DIV(S), .ADDR_W(A)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural model: mode 0 idle, 1 record, 2 play; ticks every S cycles after entry.
    logic [3:0] hist [16];
    logic [3:0] m_acc;
    int m_mode, m_slot, m_n, m_entry, m_recn, m_playn, m_last_addr;
    int m_len [2];
    int we_q [$];
    int re_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) hist[i] = '0;
        m_acc = '0;
        m_mode = 0; m_slot = 0; m_n = 0; m_entry = 0;
        m_recn = 0; m_playn = 0; m_last_addr = 0;
        m_len[0] = 0; m_len[1] = 0;
    endtask

    task automatic model_step();
        logic [3:0] raw, press;
        logic v, stable, tick;
        int e_we, e_re, e_addr, e_rec, e_play, old_recn, old_playn;
        raw = {bus.btn_play, bus.btn_record, bus.btn_play_sel, bus.btn_rec_sel};
        hist[4'(cyc)] = raw;
        if (bus.mem_we === 1'b1) we_q.push_back(int'(bus.mem_addr));
        if (bus.mem_re === 1'b1) re_q.push_back(int'(bus.mem_addr));
        if (reset) begin
            model_reset();
            return;
        end
        // A level is accepted once the raw input held it for D+1 cycles, seen 3 cycles late.
        press = '0;
        for (int b = 0; b < 4; b++) begin
            v = hist[4'(cyc - 3 - D)][b];
            stable = 1'b1;
            for (int k = 3; k < 3 + D; k++) if (hist[4'(cyc - k)][b] != v) stable = 1'b0;
            if (stable && (v != m_acc[b])) begin
                m_acc[b] = v;
                press[b] = v;
            end
        end
        e_rec = (m_mode == 1) ? 1 : 0;
        e_play = (m_mode == 2) ? 1 : 0;
        old_recn = m_recn;
        old_playn = m_playn;
        tick = (m_mode != 0) && (cyc > m_entry) && (((cyc - m_entry) % S) == 0);
        e_we = 0; e_re = 0; e_addr = m_last_addr;
        case (m_mode)
            0: begin
                if (press[0]) m_recn = 1 - m_recn;
                if (press[1]) m_playn = 1 - m_playn;
                if (press[2]) begin
                    m_mode = 1; m_slot = old_recn; m_n = 0; m_entry = cyc + 1;
                end else if (press[3] && m_len[old_playn] != 0) begin
                    m_mode = 2; m_slot = old_playn; m_n = 0; m_entry = cyc + 1;
                end
            end
            1: begin
                if (press[2]) begin
                    m_len[m_slot] = m_n; m_mode = 0;
                end else if (tick) begin
                    e_we = 1; e_addr = m_slot * (1 << A) + m_n; m_n++;
                    if (m_n == (1 << A)) begin m_len[m_slot] = m_n; m_mode = 0; end
                end
            end
            default: begin
                if (press[3]) begin
                    m_mode = 0;
                end else if (tick) begin
                    e_re = 1; e_addr = m_slot * (1 << A) + m_n; m_n++;
                    if (m_n == m_len[m_slot]) m_mode = 0;
                end
            end
        endcase
        m_last_addr = e_addr;
        chk("recording",   int'(bus.recording),   e_rec);
        chk("playing",     int'(bus.playing),     e_play);
        chk("rec_number",  int'(bus.rec_number),  old_recn);
        chk("play_number", int'(bus.play_number), old_playn);
        chk("mem_we",      int'(bus.mem_we),      e_we);
        chk("mem_re",      int'(bus.mem_re),      e_re);
        chk("mem_addr",    int'(bus.mem_addr),    e_addr);
    endtask

    task automatic drive(input int b, input logic v);
        case (b)
            0: bus.btn_rec_sel = v;
            1: bus.btn_play_sel = v;
            2: bus.btn_record = v;
            default: bus.btn_play = v;
        endcase
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press_btn(input int b);
        drive(b, 1'b1);
        step(8);
        drive(b, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((bus.recording || bus.playing) && k < 200) begin step(1); k++; end
        if (k >= 200) chk({name, "_idle_timeout"}, 1, 0);
    endtask

    task automatic wait_strobes(input string name, input int is_we, input int n);
        int k;
        k = 0;
        while (((is_we != 0) ? we_q.size() : re_q.size()) < n && k < 200) begin step(1); k++; end
        if (k >= 200) chk({name, "_strobe_timeout"}, 1, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_play_number"}, int'(bus.play_number), 0);
        chk({tag, "_rec_number"},  int'(bus.rec_number),  0);
        chk({tag, "_recording"},   int'(bus.recording),   0);
        chk({tag, "_playing"},     int'(bus.playing),     0);
        chk({tag, "_mem_we"},      int'(bus.mem_we),      0);
        chk({tag, "_mem_re"},      int'(bus.mem_re),      0);
        chk({tag, "_mem_addr"},    int'(bus.mem_addr),    0);
    endtask

    initial begin
        int mask, hold, gap;
        bus.btn_rec_sel = 1'b0; bus.btn_play_sel = 1'b0;
        bus.btn_record = 1'b0;  bus.btn_play = 1'b0;
        model_reset();
        fork
            forever begin
                @(negedge clock);
                model_step();
            end
        join_none
        step(3);
        reset = 1'b0;
        chk_all_zero("reset");

        // Play on an empty slot straight after reset.
        we_q.delete(); re_q.delete();
        press_btn(3);
        step(12);
        chk("empty_play_playing", int'(bus.playing), 0);
        chk("empty_play_reads", re_q.size(), 0);

        // Bouncing rec_sel, then a clean hold: one toggle, 8 cycles after the final rise.
        for (int i = 0; i < 10; i++) begin
            drive(0, (i % 2 == 0) ? 1'b1 : 1'b0);
            step(2);
        end
        drive(0, 1'b1);
        step(7);
        chk("debounce_before", int'(bus.rec_number), 0);
        step(1);
        chk("debounce_after", int'(bus.rec_number), 1);
        drive(0, 1'b0);
        step(10);

        // Record slot 2 to the end, then play it back.
        we_q.delete(); re_q.delete();
        press_btn(2);
        wait_idle("autostop");
        chk("autostop_writes", we_q.size(), 8);
        for (int i = 0; i < we_q.size() && i < 8; i++) chk("autostop_addr", we_q[i], 8 + i);
        press_btn(1);
        step(10);
        chk("play_sel_toggle", int'(bus.play_number), 1);
        press_btn(3);
        wait_idle("play_slot2");
        chk("play_slot2_reads", re_q.size(), 8);
        if (re_q.size() == 8) chk("play_slot2_last", re_q[7], 15);

        // Back to slot 1: record four samples, stop by button, play them.
        press_btn(0);
        step(6);
        press_btn(1);
        step(10);
        we_q.delete(); re_q.delete();
        press_btn(2);
        wait_strobes("stop_rec", 1, 2);
        press_btn(2);
        wait_idle("stop_rec");
        chk("stop_rec_writes", we_q.size(), 4);
        for (int i = 0; i < we_q.size() && i < 4; i++) chk("stop_rec_addr", we_q[i], i);
        step(10);
        press_btn(3);
        wait_idle("play4");
        chk("play4_reads", re_q.size(), 4);
        for (int i = 0; i < re_q.size() && i < 4; i++) chk("play4_addr", re_q[i], i);
        chk("play4_done", int'(bus.playing), 0);

        // Slot select is locked out while recording.
        step(10);
        press_btn(2);
        press_btn(1);
        step(2);
        chk("lockout_play_number", int'(bus.play_number), 0);
        chk("lockout_recording", int'(bus.recording), 1);
        wait_idle("lockout");
        step(10);

        // Simultaneous record and play in idle: record wins.
        drive(2, 1'b1); drive(3, 1'b1);
        step(8);
        drive(2, 1'b0); drive(3, 1'b0);
        chk("simul_recording", int'(bus.recording), 1);
        chk("simul_playing", int'(bus.playing), 0);
        wait_idle("simul");
        step(10);

        // Reset during playback after two reads.
        re_q.delete();
        press_btn(3);
        wait_strobes("midplay", 0, 2);
        chk("midplay_playing", int'(bus.playing), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk_all_zero("midplay_reset");
        step(10);
        re_q.delete();
        press_btn(3);
        step(15);
        chk("post_reset_play", int'(bus.playing), 0);
        chk("post_reset_reads", re_q.size(), 0);

        // Random button traffic including bounces and occasional resets.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) != 0) mask = 1 << $urandom_range(0, 3);
            else mask = $urandom_range(0, 15);
            hold = $urandom_range(1, 12);
            gap = $urandom_range(1, 14);
            for (int b = 0; b < 4; b++) drive(b, mask[b]);
            step(hold);
            for (int b = 0; b < 4; b++) drive(b, 1'b0);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                step(1);
                reset = 1'b0;
            end
            step(gap);
        end

        step(5);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
